// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory arbiter.
//   ramstate_t  - status reported by the RAM each cycle
//   arb_state_t - arbiter FSM states
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundles the instruction port, data port and RAM port of
// the memory arbiter.
//   slave  modport - arbiter view (requests/RAM status in, waits/strobes out)
//   master modport - environment view (requesters plus RAM model)
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  // instruction requester
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // data requester
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // RAM port
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  // status
  logic        busErr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, busErr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, busErr
  );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between an instruction requester and a
// data requester. Data has priority, but after STARVE_MAX consecutive data
// completions with an instruction request pending, the instruction side wins.
// Ports:
//   CLK  - system clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - memory_arbiter_if.slave (requester ports, RAM port, busErr)
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          bus_err_q, bus_err_d;
  logic          d_req_s;

  assign d_req_s = bus.dREN || bus.dWEN;

  // Next-state, starvation counter and sticky error computation.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        if (!bus.iREN) begin
          starve_d = '0;
        end else begin
          starve_d = starve_q;
        end
        if (d_req_s && (!bus.iREN || (starve_q < STARVE_LIM))) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end else begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        // Withdrawal: back to IDLE without a completion.
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          case (bus.ramstate)
            ACCESS: begin
              state_d  = IDLE;
              starve_d = '0;
            end
            ERROR:   bus_err_d = 1'b1;
            default: state_d   = IGRANT;
          endcase
        end
      end
      DGRANT: begin
        if (!d_req_s) begin
          state_d = IDLE;
        end else begin
          case (bus.ramstate)
            ACCESS: begin
              state_d = IDLE;
              // Count data wins only while the instruction side is waiting.
              if (bus.iREN && (starve_q < STARVE_LIM)) begin
                starve_d = starve_q + SW'(1);
              end else begin
                starve_d = starve_q;
              end
            end
            ERROR:   bus_err_d = 1'b1;
            default: state_d   = DGRANT;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, starvation counter and error flag registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      bus_err_q <= bus_err_d;
    end
  end

  // RAM port muxing and requester handshakes; waits react to ramstate in the
  // same cycle so completion costs no extra clock.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0000_0000;
    bus.ramstore = 32'h0000_0000;
    case (state_q)
      IGRANT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
      end
      DGRANT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN && !bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: begin
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
      end
    endcase
    bus.iwait  = bus.iREN && !((state_q == IGRANT) && (bus.ramstate == ACCESS));
    bus.dwait  = d_req_s  && !((state_q == DGRANT) && (bus.ramstate == ACCESS));
    bus.iload  = bus.ramload;
    bus.dload  = bus.ramload;
    bus.busErr = bus_err_q;
  end

endmodule
